// File: rtl/moo_gcm_pkg.sv
// Shared definitions for the GCM tag sequencer: GHASH op codes, state encoding,
// latched request payload and the byte-count to 16-byte-block helper.
package moo_gcm_pkg;

  localparam int unsigned TAG_W  = 128;
  localparam int unsigned SADD_W = 16;
  localparam int unsigned SMSG_W = 32;
  localparam int unsigned TLEN_W = 5;
  localparam int unsigned AADC_W = 13;
  localparam int unsigned MSGC_W = 29;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] GHASH_WRD   = 2'b00;
  localparam logic [OP_W-1:0] GHASH_ENC   = 2'b01;
  localparam logic [OP_W-1:0] GHASH_NNC_F = 2'b10;
  localparam logic [OP_W-1:0] GHASH_GCM_F = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_AAD,
    ST_MSG,
    ST_LEN,
    ST_FIN,
    ST_DONE
  } gcm_state_e;

  typedef struct packed {
    logic              decrypt;
    logic [TLEN_W-1:0] tag_len;
    logic [TAG_W-1:0]  tag_in;
  } gcm_req_t;

  // Number of 16-byte blocks needed to cover a byte count (partial block rounds up).
  function automatic logic [MSGC_W-1:0] ceil_blocks(input logic [SMSG_W-1:0] bytes);
    return MSGC_W'(bytes >> 4) + MSGC_W'(|bytes[3:0]);
  endfunction

endpackage

// File: rtl/moo_tag_cmp.sv
// Masked comparison of two 128-bit tags over the leading tag_len bytes
// (lengths outside 4..16 compare all 16 bytes).
module moo_tag_cmp
  import moo_gcm_pkg::*;
(
  input  logic [TAG_W-1:0]  tag_a_i,
  input  logic [TAG_W-1:0]  tag_b_i,
  input  logic [TLEN_W-1:0] tag_len_i,
  output logic              match_c_o
);

  logic [TLEN_W-1:0] len_eff;
  logic [7:0]        shamt;
  logic [TAG_W-1:0]  mask;

  always_comb begin
    len_eff = tag_len_i;
    if ((tag_len_i < TLEN_W'(4)) || (tag_len_i > TLEN_W'(16))) begin
      len_eff = TLEN_W'(16);
    end
    shamt     = {len_eff, 3'b000};
    mask      = ~({TAG_W{1'b1}} >> shamt);
    match_c_o = (((tag_a_i ^ tag_b_i) & mask) == '0);
  end

endmodule

// File: rtl/moo_gcm_seq.sv
// GCM authentication sequencer: clears GHASH, feeds AAD, ciphertext and length
// blocks, then forms the tag as ghash ^ E(K,J0) and verifies it on decrypt.
module moo_gcm_seq
  import moo_gcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_core,
  input  logic              start,
  input  logic              decrypt,
  input  logic [SADD_W-1:0] size_add,
  input  logic [SMSG_W-1:0] size_msg,
  input  logic [TLEN_W-1:0] tag_len,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [TAG_W-1:0]  ekj0,
  input  logic              blk_vld,
  output logic              blk_ack,
  output logic [OP_W-1:0]   ghash_op,
  output logic              ghash_en,
  output logic              ghash_clr,
  output logic              msg_done,
  input  logic              ghash_rdy,
  input  logic [TAG_W-1:0]  ghash,
  output logic              busy,
  output logic              done,
  output logic [TAG_W-1:0]  tag_out,
  output logic              auth_ok,
  output logic              auth_fail
);

  gcm_state_e        state_q, state_d;
  logic [AADC_W-1:0] aad_left_q, aad_left_d;
  logic [MSGC_W-1:0] msg_left_q, msg_left_d;
  gcm_req_t          req_q, req_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              done_q, done_d;

  logic [TAG_W-1:0]  tag_calc;
  logic              tag_match;

  assign tag_calc = ghash ^ ekj0;

  moo_tag_cmp u_tag_cmp (
    .tag_a_i   (tag_calc),
    .tag_b_i   (req_q.tag_in),
    .tag_len_i (req_q.tag_len),
    .match_c_o (tag_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      aad_left_q <= '0;
      msg_left_q <= '0;
      req_q      <= '0;
      tag_q      <= '0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aad_left_q <= aad_left_d;
      msg_left_q <= msg_left_d;
      req_q      <= req_d;
      tag_q      <= tag_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
    end
  end

  // Next-state and GHASH command decode; clr_core overrides every state.
  always_comb begin
    state_d    = state_q;
    aad_left_d = aad_left_q;
    msg_left_d = msg_left_q;
    req_d      = req_q;
    tag_d      = tag_q;
    ok_d       = ok_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    ghash_op   = GHASH_WRD;
    ghash_en   = 1'b0;
    ghash_clr  = 1'b0;
    msg_done   = 1'b0;
    blk_ack    = 1'b0;

    if (clr_core) begin
      state_d = ST_IDLE;
      tag_d   = '0;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            req_d.decrypt = decrypt;
            req_d.tag_len = tag_len;
            req_d.tag_in  = tag_in;
            aad_left_d    = AADC_W'(ceil_blocks(SMSG_W'(size_add)));
            msg_left_d    = ceil_blocks(size_msg);
            ok_d          = 1'b0;
            fail_d        = 1'b0;
            state_d       = ST_CLR;
          end
        end
        ST_CLR: begin
          ghash_clr = 1'b1;
          if (aad_left_q != '0)      state_d = ST_AAD;
          else if (msg_left_q != '0) state_d = ST_MSG;
          else                       state_d = ST_LEN;
        end
        ST_AAD: begin
          ghash_op = GHASH_WRD;
          ghash_en = blk_vld & ghash_rdy;
          blk_ack  = ghash_en;
          if (ghash_en) begin
            aad_left_d = aad_left_q - AADC_W'(1);
            if (aad_left_q == AADC_W'(1)) begin
              state_d = (msg_left_q != '0) ? ST_MSG : ST_LEN;
            end
          end
        end
        ST_MSG: begin
          ghash_op = GHASH_ENC;
          msg_done = (msg_left_q == MSGC_W'(1));
          ghash_en = blk_vld & ghash_rdy;
          blk_ack  = ghash_en;
          if (ghash_en) begin
            msg_left_d = msg_left_q - MSGC_W'(1);
            if (msg_left_q == MSGC_W'(1)) state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          ghash_op = GHASH_GCM_F;
          ghash_en = ghash_rdy;
          if (ghash_rdy) state_d = ST_FIN;
        end
        ST_FIN: begin
          if (ghash_rdy) begin
            tag_d = tag_calc;
            if (req_q.decrypt) begin
              ok_d   = tag_match;
              fail_d = ~tag_match;
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign tag_out   = tag_q;
  assign auth_ok   = ok_q;
  assign auth_fail = fail_q;

endmodule
